// File: rtl/demux1_4_seq.sv
// demux1_4_seq: steers one input stream into four one-entry lane registers, by s or round-robin ptr.
// Latency 1 cycle; in_ready drops only while the target lane is full and not draining, stalling the source.
module demux1_4_seq #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       s,
  input  logic             auto,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [1:0]       ptr,
  output logic [7:0]       xfer_cnt
);

  logic [WIDTH-1:0] lane_dat [4];
  logic [1:0]       tgt;
  logic [3:0]       drain;
  logic [3:0]       load;
  logic             accept;

  // Only the target lane gates acceptance; a lane draining this cycle can take a new word with no bubble.
  always_comb begin
    tgt      = auto ? ptr : s;
    in_ready = ~o_valid[tgt] | o_ready[tgt];
    accept   = in_valid & in_ready;
    drain    = o_valid & o_ready;
    load     = 4'b0000;
    if (accept) begin
      load[tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        lane_dat[k] <= '0;
      end
      o_valid  <= 4'b0000;
      ptr      <= 2'd0;
      xfer_cnt <= 8'd0;
    end else begin
      // Drained lanes keep their last word; only o_valid falls.
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          lane_dat[k] <= in_data;
        end
      end
      o_valid <= (o_valid & ~drain) | load;
      if (accept) begin
        xfer_cnt <= xfer_cnt + 8'd1;
        if (auto) begin
          ptr <= ptr + 2'd1;
        end
      end
    end
  end

  assign o0 = lane_dat[0];
  assign o1 = lane_dat[1];
  assign o2 = lane_dat[2];
  assign o3 = lane_dat[3];

endmodule

// File: tb/tb_demux1_4_seq.sv
// Randomized and directed bench for demux1_4_seq with per-lane expected-word queues.
module tb_demux1_4_seq;
  localparam int WIDTH = 2;
  typedef logic [WIDTH-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       s;
  logic             auto;
  logic [WIDTH-1:0] o0, o1, o2, o3;
  logic [3:0]       o_valid;
  logic [3:0]       o_ready;
  logic [1:0]       ptr;
  logic [7:0]       xfer_cnt;

  demux1_4_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .auto     (auto),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .ptr      (ptr),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each lane is a queue of words waiting for the consumer.
  word_t      exp_q [4][$];
  word_t      mdat [4];
  logic [1:0] mptr;
  logic [7:0] mcnt;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  word_t      o_arr [4];

  always_comb o_arr = '{o0, o1, o2, o3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      mdat[k] = '0;
    end
    mptr = 2'd0;
    mcnt = 8'd0;
  endfunction

  // Monitor: compares lane state every cycle and pops a word whenever the consumer takes one.
  always @(negedge clk) begin
    word_t w;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), {31'd0, o_valid[k]}, {31'd0, exp_q[k].size() != 0});
        chk($sformatf("data%0d", k), {30'd0, o_arr[k]}, {30'd0, mdat[k]});
        if (o_valid[k] && o_ready[k] && exp_q[k].size() != 0) begin
          w = exp_q[k].pop_front();
          chk($sformatf("drain%0d", k), {30'd0, o_arr[k]}, {30'd0, w});
        end
      end
      chk("ptr", {30'd0, ptr}, {30'd0, mptr});
      chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, mcnt});
    end
  end

  // One clock: after the monitor has run, decide acceptance from the model and record it.
  task automatic tick();
    logic [1:0] t;
    bit         rdy_exp;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      model_clear();
    end else begin
      t       = auto ? mptr : s;
      rdy_exp = (exp_q[t].size() == 0) || o_ready[t];
      if (mon_en) chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
      if (in_valid && rdy_exp) begin
        exp_q[t].push_back(in_data);
        mdat[t] = in_data;
        mcnt++;
        if (auto) mptr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input word_t d, input logic [1:0] sel, input bit au,
                       input logic [3:0] rdy);
    in_valid = v;
    in_data  = d;
    s        = sel;
    auto     = au;
    o_ready  = rdy;
    tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    s        = 2'd0;
    auto     = 1'b0;
    o_ready  = 4'b0000;
    model_clear();

    // Reset then explicit steering
    do_reset(2);
    chk("rst_valid", {28'd0, o_valid}, 32'h0);
    chk("rst_ptr", {30'd0, ptr}, 32'h0);
    chk("rst_cnt", {24'd0, xfer_cnt}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
    drive(1'b1, 2'b01, 2'd2, 1'b0, 4'b1111);
    chk("tp1_o2", {30'd0, o2}, 32'h1);
    chk("tp1_valid_a", {28'd0, o_valid}, 32'h4);
    drive(1'b1, 2'b11, 2'd0, 1'b0, 4'b1111);
    chk("tp1_o0", {30'd0, o0}, 32'h3);
    chk("tp1_valid_b", {28'd0, o_valid}, 32'h1);
    chk("tp1_cnt", {24'd0, xfer_cnt}, 32'h2);
    chk("tp1_ptr", {30'd0, ptr}, 32'h0);

    // Round-robin wrap
    begin
      word_t words [5];
      words = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, words[i], 2'd0, 1'b1, 4'b1111);
        chk("rr_ptr", {30'd0, ptr}, (i + 1) % 4);
      end
    end
    chk("rr_o0", {30'd0, o0}, 32'h1);
    chk("rr_o3", {30'd0, o3}, 32'h3);

    // Backpressure stall on lane 1
    drive(1'b0, 2'b00, 2'd1, 1'b0, 4'b1111);
    drive(1'b1, 2'b10, 2'd1, 1'b0, 4'b0000);
    chk("stall_o1", {30'd0, o1}, 32'h2);
    in_data = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rdy", {31'd0, in_ready}, 32'h0);
      chk("stall_hold", {30'd0, o1}, 32'h2);
    end
    o_ready = 4'b0010;
    #1;
    chk("unstall_rdy", {31'd0, in_ready}, 32'h1);
    tick();
    chk("unstall_o1", {30'd0, o1}, 32'h1);
    chk("unstall_v1", {31'd0, o_valid[1]}, 32'h1);
    drive(1'b0, 2'b00, 2'd0, 1'b0, 4'b1111);

    // Independent lanes
    drive(1'b1, 2'b11, 2'd3, 1'b0, 4'b0000);
    in_data = 2'b10;
    s       = 2'd0;
    #1;
    chk("indep_rdy", {31'd0, in_ready}, 32'h1);
    tick();
    chk("indep_o0", {30'd0, o0}, 32'h2);
    chk("indep_o3", {30'd0, o3}, 32'h3);
    chk("indep_v3", {31'd0, o_valid[3]}, 32'h1);
    drive(1'b0, 2'b00, 2'd0, 1'b0, 4'b1111);

    // Counter wrap after 256 accepts from reset
    do_reset(1);
    for (int i = 0; i < 256; i++) drive(1'b1, word_t'($urandom_range(0, 3)), 2'd0, 1'b1, 4'b1111);
    chk("wrap_cnt", {24'd0, xfer_cnt}, 32'h0);
    chk("wrap_ptr", {30'd0, ptr}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, word_t'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) < 4), 4'($urandom_range(0, 15)));
    end

    // Mid-run reset with all lanes full
    for (int k = 0; k < 4; k++) drive(1'b1, word_t'(k ^ 1), 2'(k), 1'b0, 4'b0000);
    chk("full_valid", {28'd0, o_valid}, 32'hf);
    in_valid = 1'b1;
    in_data  = 2'b11;
    rst_n    = 1'b0;
    tick();
    chk("mrst_valid", {28'd0, o_valid}, 32'h0);
    chk("mrst_data", {24'd0, o3, o2, o1, o0}, 32'h0);
    chk("mrst_cnt", {24'd0, xfer_cnt}, 32'h0);
    chk("mrst_ptr", {30'd0, ptr}, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 2'd0, 1'b0, 4'b1111);
    drive(1'b0, 2'b00, 2'd0, 1'b0, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
